// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
//  Module      : key_scan
//  Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//                samples the row lines once per column slot, builds a 16-bit
//                frame snapshot and debounces whole frames before emitting a
//                one-cycle key event with a 4-bit key code.
//
//  Ports
//    sys_clk      in   1  system clock, rising edge
//    sys_rst_n    in   1  asynchronous active-low reset
//    key_row      in   4  keypad rows, pulled up, low = closed (async input)
//    key_col      out  4  column drive, exactly one bit low (registered)
//    key_code     out  4  last accepted key, row*4 + col (registered, held)
//    key_valid    out  1  one-cycle pulse per accepted press
//    key_pressed  out  1  high from accept until release is accepted
//
//  Parameters
//    SCAN_DIV     sys_clk cycles per column slot (>= 4)
//    DB_FRAMES    identical consecutive frames to accept press/release (1..15)
//
//  Revision    : 1.0  initial release
// ============================================================================
module key_scan #(
    parameter int SCAN_DIV  = 50_000,
    parameter int DB_FRAMES = 5
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [3:0]         c_DB_LAST   = 4'(DB_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;

    logic [c_CNT_W-1:0] r_slot_cnt;
    logic [1:0]         r_col_idx;
    logic               w_slot_end;
    logic               w_frame_end;

    logic [15:0]        r_snap;
    logic [15:0]        w_col_bits;
    logic [15:0]        w_frame;

    logic [4:0]         w_ones;
    logic [3:0]         w_bit_idx;
    logic               w_is_none;
    logic               w_is_single;
    logic [3:0]         w_code;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cand_code;
    logic [3:0]         w_cand_nxt;
    logic [3:0]         r_match_cnt;
    logic [3:0]         w_match_nxt;
    logic [3:0]         r_rel_cnt;
    logic [3:0]         w_rel_nxt;
    logic               w_accept;
    logic               w_release;

    // ------------------------------------------------------------------------
    // Row synchronizer. Idle level of the rows is all-ones (pull-ups), so the
    // flops reset to "no key" rather than to zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= key_row;
            r_row_sync <= r_row_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Slot counter and column rotation. The column index is kept alongside
    // the one-cold drive so the snapshot position needs no encoder.
    // ------------------------------------------------------------------------
    assign w_slot_end  = (r_slot_cnt == c_SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_col_idx == 2'd3);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_slot_cnt <= '0;
            r_col_idx  <= 2'd0;
            key_col    <= 4'b1110;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_col_idx  <= r_col_idx + 2'd1;
            key_col    <= {key_col[2:0], key_col[3]};
        end else begin
            r_slot_cnt <= r_slot_cnt + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Frame snapshot. Bit [col*4 + row] is set when that key is closed. The
    // frame-end classification uses w_frame (snapshot merged with the column 3
    // sample of this very cycle), so the register itself can simply clear.
    // ------------------------------------------------------------------------
    assign w_col_bits = {12'd0, ~r_row_sync} << {r_col_idx, 2'b00};
    assign w_frame    = r_snap | w_col_bits;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_snap <= '0;
        end else if (w_slot_end) begin
            r_snap <= w_frame_end ? 16'd0 : w_frame;
        end
    end

    // ------------------------------------------------------------------------
    // Frame classifier: count set bits and remember the index of a set bit.
    // The index is only meaningful when exactly one bit is set.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ones    = 5'd0;
        w_bit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame[i]) begin
                w_ones    = w_ones + 5'd1;
                w_bit_idx = 4'(i);
            end
        end
    end

    assign w_is_none   = (w_ones == 5'd0);
    assign w_is_single = (w_ones == 5'd1);
    // Snapshot index is col*4+row; the key code is row*4+col.
    assign w_code      = {w_bit_idx[1:0], w_bit_idx[3:2]};

    // ------------------------------------------------------------------------
    // Debounce FSM, next-state logic. Only frame ends move it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand_code;
        w_match_nxt = r_match_cnt;
        w_rel_nxt   = r_rel_cnt;
        w_accept    = 1'b0;
        w_release   = 1'b0;

        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_single) begin
                        w_cand_nxt = w_code;
                        if (c_DB_LAST == 4'd1) begin
                            w_state_nxt = ST_HELD;
                            w_accept    = 1'b1;
                            w_match_nxt = 4'd0;
                            w_rel_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = ST_DEBOUNCE;
                            w_match_nxt = 4'd1;
                        end
                    end
                end

                ST_DEBOUNCE: begin
                    if (w_is_single) begin
                        if (w_code == r_cand_code) begin
                            if (r_match_cnt + 4'd1 == c_DB_LAST) begin
                                w_state_nxt = ST_HELD;
                                w_accept    = 1'b1;
                                w_match_nxt = 4'd0;
                                w_rel_nxt   = 4'd0;
                            end else begin
                                w_match_nxt = r_match_cnt + 4'd1;
                            end
                        end else begin
                            // A different single key restarts the candidate.
                            w_cand_nxt  = w_code;
                            w_match_nxt = 4'd1;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_match_nxt = 4'd0;
                    end
                end

                ST_HELD: begin
                    if (w_is_none) begin
                        if (r_rel_cnt + 4'd1 == c_DB_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_rel_nxt   = 4'd0;
                            w_release   = 1'b1;
                        end else begin
                            w_rel_nxt = r_rel_cnt + 4'd1;
                        end
                    end else begin
                        // Any key activity while held restarts the release
                        // count; no new event until a full release.
                        w_rel_nxt = 4'd0;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_match_nxt = 4'd0;
                    w_rel_nxt   = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM state and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_cand_code <= 4'd0;
            r_match_cnt <= 4'd0;
            r_rel_cnt   <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand_code <= w_cand_nxt;
            r_match_cnt <= w_match_nxt;
            r_rel_cnt   <= w_rel_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            key_valid <= w_accept;
            if (w_accept) begin
                key_code    <= w_cand_nxt;
                key_pressed <= 1'b1;
            end else if (w_release) begin
                key_pressed <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
